// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the sequential binarized classifier.
package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HID  = 2'd1,
      CLS  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic int sum_bits(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // A feature counts as "high" at half scale and above, i.e. its MSB is set.
   function automatic logic binarize(input logic [31:0] f, input int bits);
      return f >= (32'd1 << (bits - 1));
   endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational match counter: number of positions where a and b agree.
module bnn_xnor_popcount #(
   parameter int N = 8
) (
   input  logic [N-1:0]             a,
   input  logic [N-1:0]             b,
   output logic [$clog2(N+1)-1:0]   cnt
);
   localparam int W = $clog2(N + 1);

   logic [N-1:0] match;

   assign match = ~(a ^ b);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + W'(match[i]);
      end
   end

endmodule

// File: rtl/bnn_seq_classifier_hs.sv
// Sequential ROM-weighted BNN classifier with start/busy/valid handshake.
// state | meaning
// IDLE  | waiting for start; features binarized and latched on accept
// HID   | LANES hidden neurons evaluated per cycle
// CLS   | one class score per cycle, running strict-greater argmax
// DONE  | publish prediction/score, pulse valid, return to IDLE
module bnn_seq_classifier_hs
   import bnn_pkg::*;
#(
   parameter int FEAT_CNT   = 128,
   parameter int FEAT_BITS  = 4,
   parameter int HIDDEN_CNT = 40,
   parameter int CLASS_CNT  = 6,
   parameter int LANES      = 1,
   parameter int H_THR      = FEAT_CNT / 2,
   parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
   parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [FEAT_BITS*FEAT_CNT-1:0]      features,
   output logic                               busy,
   output logic                               valid,
   output logic [idx_bits(CLASS_CNT)-1:0]     prediction,
   output logic [sum_bits(HIDDEN_CNT)-1:0]    score
);
   localparam int SUM_H  = sum_bits(FEAT_CNT);
   localparam int SUM_C  = sum_bits(HIDDEN_CNT);
   localparam int IDX_W  = idx_bits(CLASS_CNT);
   localparam int HCNT_W = sum_bits(HIDDEN_CNT);
   localparam int CCNT_W = sum_bits(CLASS_CNT);

   if (HIDDEN_CNT % LANES != 0) begin : g_lanes_check
      $error("LANES must divide HIDDEN_CNT");
   end

   state_e                  state_q, state_d;
   logic [FEAT_CNT-1:0]     xb_q, xb_d;
   logic [HIDDEN_CNT-1:0]   hidden_q, hidden_d;
   logic [HCNT_W-1:0]       hcnt_q, hcnt_d;
   logic [CCNT_W-1:0]       ccnt_q, ccnt_d;
   logic [SUM_C-1:0]        best_score_q, best_score_d;
   logic [IDX_W-1:0]        best_idx_q, best_idx_d;
   logic                    busy_q, busy_d;
   logic                    valid_q, valid_d;
   logic [IDX_W-1:0]        pred_q, pred_d;
   logic [SUM_C-1:0]        score_q, score_d;

   logic [FEAT_CNT-1:0]     xb_in;
   logic [FEAT_CNT-1:0]     w1_rom [HIDDEN_CNT];
   logic [HIDDEN_CNT-1:0]   w2_rom [CLASS_CNT];
   logic [HCNT_W-1:0]       lane_h [LANES];
   logic [FEAT_CNT-1:0]     w1_row [LANES];
   logic [SUM_H-1:0]        hid_sum [LANES];
   logic [LANES-1:0]        hid_fire;
   logic [SUM_C-1:0]        cls_sum;

   for (genvar i = 0; i < FEAT_CNT; i++) begin : g_bin
      assign xb_in[i] = binarize(32'(features[i*FEAT_BITS +: FEAT_BITS]), FEAT_BITS);
   end

   for (genvar h = 0; h < HIDDEN_CNT; h++) begin : g_w1
      assign w1_rom[h] = W1[h*FEAT_CNT +: FEAT_CNT];
   end

   for (genvar c = 0; c < CLASS_CNT; c++) begin : g_w2
      assign w2_rom[c] = W2[c*HIDDEN_CNT +: HIDDEN_CNT];
   end

   // hcnt_q is always a multiple of LANES and never exceeds HIDDEN_CNT-LANES,
   // so every lane index stays inside the weight ROM.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_h[l] = hcnt_q + HCNT_W'(l);
      assign w1_row[l] = w1_rom[lane_h[l]];

      bnn_xnor_popcount #(.N(FEAT_CNT)) u_hid_pc (
         .a   (xb_q),
         .b   (w1_row[l]),
         .cnt (hid_sum[l])
      );

      assign hid_fire[l] = (hid_sum[l] >= SUM_H'(H_THR));
   end

   bnn_xnor_popcount #(.N(HIDDEN_CNT)) u_cls_pc (
      .a   (hidden_q),
      .b   (w2_rom[ccnt_q]),
      .cnt (cls_sum)
   );

   always_comb begin
      state_d      = state_q;
      xb_d         = xb_q;
      hidden_d     = hidden_q;
      hcnt_d       = hcnt_q;
      ccnt_d       = ccnt_q;
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
      busy_d       = busy_q;
      valid_d      = 1'b0;
      pred_d       = pred_q;
      score_d      = score_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               xb_d    = xb_in;
               hcnt_d  = '0;
               busy_d  = 1'b1;
               state_d = HID;
            end
         end
         HID: begin
            for (int l = 0; l < LANES; l++) begin
               hidden_d[lane_h[l]] = hid_fire[l];
            end
            if (hcnt_q == HCNT_W'(HIDDEN_CNT - LANES)) begin
               ccnt_d       = '0;
               best_score_d = '0;
               best_idx_d   = '0;
               state_d      = CLS;
            end else begin
               hcnt_d = hcnt_q + HCNT_W'(LANES);
            end
         end
         CLS: begin
            // Strict compare keeps the lowest index on ties.
            if (cls_sum > best_score_q) begin
               best_score_d = cls_sum;
               best_idx_d   = IDX_W'(ccnt_q);
            end
            if (ccnt_q == CCNT_W'(CLASS_CNT - 1)) begin
               state_d = DONE;
            end else begin
               ccnt_d = ccnt_q + CCNT_W'(1);
            end
         end
         DONE: begin
            pred_d  = best_idx_q;
            score_d = best_score_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         xb_q         <= '0;
         hidden_q     <= '0;
         hcnt_q       <= '0;
         ccnt_q       <= '0;
         best_score_q <= '0;
         best_idx_q   <= '0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         pred_q       <= '0;
         score_q      <= '0;
      end else begin
         state_q      <= state_d;
         xb_q         <= xb_d;
         hidden_q     <= hidden_d;
         hcnt_q       <= hcnt_d;
         ccnt_q       <= ccnt_d;
         best_score_q <= best_score_d;
         best_idx_q   <= best_idx_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         pred_q       <= pred_d;
         score_q      <= score_d;
      end
   end

   assign busy       = busy_q;
   assign valid      = valid_q;
   assign prediction = pred_q;
   assign score      = score_q;

endmodule

// File: tb/tb_bnn_seq_classifier_hs.sv
// Scoreboard bench for bnn_seq_classifier_hs: three weight/lane configurations.
module tb_bnn_seq_classifier_hs;
   localparam int FC = 128;
   localparam int FB = 4;
   localparam int HC = 40;
   localparam int CC = 6;

   localparam logic [HC*FC-1:0] W1_ONES = '1;
   localparam logic [CC*HC-1:0] W2_C3   = {{2{40'h0}}, 40'hFF_FFFF_FFFF, {3{40'h0}}};
   localparam logic [CC*HC-1:0] W2_TIE  = {6{40'hFF_FFFF_FF00}};

   typedef struct {
      int id;
      int pred;
      int score;
      int start_edge;
      int lat;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [FB*FC-1:0] features;
   logic             start_v [3];
   logic             busy_v  [3];
   logic             valid_v [3];
   logic [2:0]       pred_v  [3];
   logic [5:0]       score_v [3];

   exp_t sbq [$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;
   int   vcnt [3] = '{0, 0, 0};
   logic vprev [3] = '{1'b0, 1'b0, 1'b0};

   bnn_seq_classifier_hs #(.FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
      .LANES(1), .H_THR(FC/2), .W1(W1_ONES), .W2(W2_C3)) dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .features(features),
      .busy(busy_v[0]), .valid(valid_v[0]), .prediction(pred_v[0]), .score(score_v[0]));

   bnn_seq_classifier_hs #(.FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
      .LANES(1), .H_THR(FC/2), .W1('0), .W2(W2_TIE)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .features(features),
      .busy(busy_v[1]), .valid(valid_v[1]), .prediction(pred_v[1]), .score(score_v[1]));

   bnn_seq_classifier_hs #(.FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
      .LANES(4), .H_THR(FC/2), .W1(W1_ONES), .W2(W2_C3)) dut_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .features(features),
      .busy(busy_v[2]), .valid(valid_v[2]), .prediction(pred_v[2]), .score(score_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse pops the oldest expectation.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (valid_v[i]) begin
            vcnt[i]++;
            check($sformatf("valid_width_dut%0d", i), 32'(vprev[i]), 0);
            if (sbq.size() == 0) begin
               check($sformatf("unexpected_valid_dut%0d", i), 1, 0);
            end else begin
               mon_e = sbq.pop_front();
               check("valid_source", i, mon_e.id);
               check($sformatf("prediction_dut%0d", i), 32'(pred_v[i]), mon_e.pred);
               check($sformatf("score_dut%0d", i), 32'(score_v[i]), mon_e.score);
               check($sformatf("latency_dut%0d", i), edge_n - mon_e.start_edge, mon_e.lat);
            end
         end
      end
      for (int i = 0; i < 3; i++) vprev[i] = valid_v[i];
   end

   function automatic logic [FB*FC-1:0] fill(input logic [FB-1:0] v);
      logic [FB*FC-1:0] r;
      for (int i = 0; i < FC; i++) r[i*FB +: FB] = v;
      return r;
   endfunction

   // First n features at 8 (binarize to 1), the rest at 7 (binarize to 0).
   function automatic logic [FB*FC-1:0] split(input int n);
      logic [FB*FC-1:0] r;
      for (int i = 0; i < FC; i++) r[i*FB +: FB] = (i < n) ? 4'd8 : 4'd7;
      return r;
   endfunction

   function automatic logic [FB*FC-1:0] alternate();
      logic [FB*FC-1:0] r;
      for (int i = 0; i < FC; i++) r[i*FB +: FB] = (i % 2 == 0) ? 4'd15 : 4'd0;
      return r;
   endfunction

   task automatic wait_drain();
      int t = 0;
      while (sbq.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", sbq.size(), 0);
   endtask

   task automatic run(input int id, input logic [FB*FC-1:0] f, input int pred,
                      input int score, input int lat, input logic [FB*FC-1:0] f_late);
      exp_t e;
      @(negedge clk);
      features     = f;
      e.id         = id;
      e.pred       = pred;
      e.score      = score;
      e.start_edge = edge_n + 1;
      e.lat        = lat;
      sbq.push_back(e);
      start_v[id] = 1'b1;
      @(negedge clk);
      start_v[id] = 1'b0;
      check("busy_after_start", 32'(busy_v[id]), 1);
      features = f_late;
      wait_drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   s;
      int   vc;
      exp_t e;
      rst      = 1'b0;
      features = '0;
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset_busy_dut%0d", i), 32'(busy_v[i]), 0);
         check($sformatf("reset_valid_dut%0d", i), 32'(valid_v[i]), 0);
         check($sformatf("reset_pred_dut%0d", i), 32'(pred_v[i]), 0);
         check($sformatf("reset_score_dut%0d", i), 32'(score_v[i]), 0);
      end
      rst = 1'b1;

      run(0, fill(4'd8), 3, 40, 47, fill(4'd7));
      run(0, fill(4'd7), 0, 40, 47, fill(4'd8));
      run(0, split(63), 0, 40, 47, fill(4'd15));
      run(0, split(64), 3, 40, 47, fill(4'd0));

      // Reset in the middle of HID discards the job and clears outputs.
      @(negedge clk);
      features   = fill(4'd8);
      s          = edge_n + 1;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      while (edge_n < s + 9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midreset_busy", 32'(busy_v[0]), 0);
      check("midreset_valid", 32'(valid_v[0]), 0);
      check("midreset_pred", 32'(pred_v[0]), 0);
      check("midreset_score", 32'(score_v[0]), 0);
      vc = vcnt[0];
      repeat (60) @(negedge clk);
      check("midreset_no_valid", vcnt[0], vc);
      run(0, fill(4'd8), 3, 40, 47, fill(4'd8));

      run(1, fill(4'd0), 0, 32, 47, fill(4'd15));
      run(1, fill(4'd15), 0, 8, 47, fill(4'd0));
      run(1, alternate(), 0, 32, 47, fill(4'd15));

      run(2, fill(4'd8), 3, 40, 17, fill(4'd7));
      run(2, fill(4'd7), 0, 40, 17, fill(4'd8));

      // start held high: back-to-back jobs every 48 cycles.
      @(negedge clk);
      features = fill(4'd8);
      s        = edge_n + 1;
      vc       = vcnt[0];
      for (int k = 0; k < 3; k++) begin
         e.id = 0; e.pred = 3; e.score = 40; e.start_edge = s + 48 * k; e.lat = 47;
         sbq.push_back(e);
      end
      start_v[0] = 1'b1;
      while (edge_n < s + 143) @(negedge clk);
      start_v[0] = 1'b0;
      wait_drain();
      repeat (60) @(negedge clk);
      check("held_start_result_count", vcnt[0] - vc, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bnn_seq_classifier_hs.md
Name: bnn_seq_classifier_hs

Overview:
- Sequential, ROM-weighted binarized neural network classifier: binarize features → one hidden layer → argmax over class scores.
- Successor to the fixed-latency bnnromex core. Adds:
  - a start/busy/valid handshake;
  - configurable hidden-layer parallelism (LANES);
  - a score output;
  - a defined tie-break.
- Sits between the feature front-end and the result collector in the gas/sensor classification designs.

Parameters:
- FEAT_CNT, 128, number of input features
- FEAT_BITS, 4, bits per feature (unsigned)
- HIDDEN_CNT, 40, hidden neurons
- CLASS_CNT, 6, output classes
- LANES, 1, hidden neurons evaluated per cycle; must divide HIDDEN_CNT (elaboration error otherwise)
- H_THR, FEAT_CNT/2, hidden neuron fires when its popcount is >= H_THR
- W1, all zeros, HIDDEN_CNT*FEAT_CNT bits; neuron h occupies bits [h*FEAT_CNT +: FEAT_CNT]
- W2, all zeros, CLASS_CNT*HIDDEN_CNT bits; class c occupies bits [c*HIDDEN_CNT +: HIDDEN_CNT]

Ports:
- clk, input, 1, sole clock, rising edge
- rst, input, 1, synchronous, active-low reset
- start, input, 1, request a classification; sampled only in IDLE
- features, input, FEAT_BITS*FEAT_CNT, packed features; feature i is [i*FEAT_BITS +: FEAT_BITS]
- busy, output, 1, high from the cycle after start is accepted until valid
- valid, output, 1, one-cycle pulse when prediction/score update
- prediction, output, clog2(CLASS_CNT), winning class index
- score, output, clog2(HIDDEN_CNT+1), winning class popcount

Behaviour:
- Reset (rst=0 at a rising edge):
  - state←IDLE.
  - busy, valid, prediction, score, all counters and the hidden register ←0.
  - Takes priority over every other event, including mid-operation; a partial result is discarded and valid is not asserted.
- Binarization: xb[i] = features[i] >= 2^(FEAT_BITS-1), i.e. the MSB of feature i.
- FSM states are IDLE, HID, CLS, DONE.
- IDLE:
  - On start=1, latch xb into an internal register; neuron counter←0; state←HID.
  - Features are not sampled again until the next accepted start.
- HID:
  - Each cycle, for lanes l=0..LANES-1 with h = cnt+l: hidden[h] = popcount(~(xb ^ W1[h])) >= H_THR.
  - cnt += LANES.
  - After HIDDEN_CNT/LANES cycles: state←CLS, class counter←0, best_score←0, best_idx←0.
- CLS:
  - One class per cycle: s = popcount(~(hidden ^ W2[c])).
  - Update best when s > best_score, strict compare, so on ties the lowest index wins; class 0 always initializes best.
  - After CLASS_CNT cycles: state←DONE.
- DONE:
  - prediction←best_idx, score←best_score, valid=1 for exactly one cycle, busy←0, state←IDLE.
- Latency: start sampled at edge 0 → valid high after edge HIDDEN_CNT/LANES + CLASS_CNT + 1.
  - LANES=1 with default counts: 47 cycles.
- Throughput:
  - A new start is accepted on the same edge on which valid deasserts, i.e. in the first IDLE cycle.
  - start is ignored while busy; no queuing.
- prediction/score hold their last values until the next DONE; reset clears them to 0.
- Arithmetic:
  - Popcounts are unsigned, sized clog2(N+1); no overflow is possible.
  - Counter widths are clog2 of the count + 1.
  - The counters never wrap past their limit; they are compared against the limit before increment.

Decomposition:
- Package bnn_pkg holds:
  - the FSM state enum (IDLE/HID/CLS/DONE, 2 bits);
  - width helper constants/functions (clog2-based SUM_BITS, IDX_BITS);
  - the binarization threshold function.
- One combinational sub-module, bnn_xnor_popcount, with parameter N:
  - inputs a[N], b[N];
  - output cnt[clog2(N+1)] = popcount(~(a^b)).
  - Instantiated LANES times for the hidden layer and once for the class layer.

Test Plan:
- Reset mid-HID: start, then rst=0 at cycle 10 → busy=0, valid never pulses, prediction=0, score=0; a subsequent start completes normally.
- W1 all ones, all features=8, W2 class 3 all ones and others all zeros, LANES=1 → hidden all 1; valid at cycle 47 with prediction=3, score=40.
- Same setup with all features=7 → hidden all 0; class 3 score=0, others 40; prediction=0 (tie among 0,1,2,4,5 → lowest), score=40.
- Tie test: W2 all classes identical → prediction=0 regardless of input.
- LANES=4 with the scenario 2 weights → identical prediction=3, score=40; valid at cycle 10+6+1=17.
- Handshake:
  - start held high continuously → one result per 48 cycles (47 + 1 IDLE);
  - features changed while busy do not affect the result;
  - valid is exactly one cycle wide.
